reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Multi-ported, parametrised integer register file for the ARM datapath; successor to the single-write/dual-read register block.
- Provides NUM_READ combinational read ports and two write ports (ALU result and load/second result).
- Hardwires an architectural zero register (XZR).
- Runs a post-reset clear sweep with a ready indication, so the file never holds X after reset.

Parameters:
DATA_WIDTH, 64, register width in bits
ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH entries
NUM_READ, 3, number of read ports (1..4)
ZERO_REG, 31, index of the hardwired-zero register
ZERO_REG_EN, 1, 1 = ZERO_REG reads 0 and ignores writes; 0 = ZERO_REG is ordinary storage

Ports:
clock  in  1  single clock, all state updates on rising edge
reset_n  in  1  synchronous, active-low reset
read_addr  in  NUM_READ*ADDR_WIDTH  packed read indices; port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
read_data  out  NUM_READ*DATA_WIDTH  packed read data; port k at [k*DATA_WIDTH +: DATA_WIDTH]
write_en0  in  1  write port 0 enable
write_addr0  in  ADDR_WIDTH  write port 0 index
write_data0  in  DATA_WIDTH  write port 0 data
write_en1  in  1  write port 1 enable
write_addr1  in  ADDR_WIDTH  write port 1 index
write_data1  in  DATA_WIDTH  write port 1 data
ready  out  1  high once clear sweep is done; writes accepted only when high
write_collision  out  1  registered one-cycle pulse: both ports wrote the same non-zero index

Behaviour:
- Interface: one clock, `clock`. Reset `reset_n` is synchronous and active-low, sampled only on the rising edge of `clock`.
- State machine, two states: CLEAR, RUN.
- reset_n=0 at an edge:
  - state <= CLEAR; clear_idx <= 0
  - ready <= 0; write_collision <= 0
  - No storage write occurs that edge.
- CLEAR:
  - Each edge with reset_n=1: entry[clear_idx] <= 0, clear_idx <= clear_idx+1.
  - The edge that clears entry DEPTH-1 moves to RUN and sets ready <= 1.
  - Sweep length is DEPTH cycles after reset release (32 by default). ready rises on the edge that clears the last entry.
  - write_en0/1 are ignored throughout CLEAR.
  - All read_data ports drive 0 while in CLEAR.
- Reset asserted mid-sweep or in RUN: the sweep restarts from index 0. Reset has priority over everything.
- RUN, writes:
  - At an edge, if write_enX=1, entry[write_addrX] <= write_dataX.
  - If ZERO_REG_EN=1 and write_addrX==ZERO_REG, that write is dropped.
  - Both ports enabled with the same index: port 1 wins. write_collision is 1 for exactly the following cycle, unless the index is a dropped ZERO_REG write.
  - Different indices: both writes complete in the same edge.
- RUN, reads:
  - Combinational, zero latency: read_data[k] = entry[read_addr[k]].
  - ZERO_REG reads 0 when ZERO_REG_EN=1.
  - All NUM_READ ports are independent; any port may read any index, including duplicates.
- Write-to-read same cycle: governed by the optional feature below.
- Address width rule: indices are used unmodified; DEPTH always equals 2**ADDR_WIDTH, so there is no out-of-range case.
- No delay annotations in RTL; timing comes from synthesis.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read port whose address matches an enabled, non-dropped write in the same cycle returns that write data combinationally.
  - On a dual-write match, port 1 data is returned, consistent with the write priority.
  - Bypass is inactive in CLEAR.
- Undefined: reads return the pre-edge stored value; new data is visible from the cycle after the write edge.

Decomposition:
- Package reg_file_pkg holds:
  - typedef for the state (CLEAR/RUN)
  - constant XZR_INDEX = 31
  - default DATA_WIDTH/ADDR_WIDTH constants shared with the decode stage and hazard unit
- One natural sub-module: reg_file_read_port. It handles a single read with zero-reg masking, bypass muxing and CLEAR forcing, and is instantiated NUM_READ times via generate.
- Storage, the write logic and the FSM stay in the top.

Test Plan:
- Reset sweep: hold reset_n=0 for 2 cycles, release -> ready=0 for 31 edges, ready=1 on the 32nd edge; every index then reads 0.
- Basic write/read: write 0xDEAD_BEEF_0000_0001 to index 5 via port 0 -> next cycle read port 2 at index 5 returns that value; with REGFILE_BYPASS_EN, port 2 returns it in the same cycle as the write.
- Collision: port 0 writes 0x11 and port 1 writes 0x22, both to index 7 -> index 7 reads 0x22; write_collision=1 for exactly one cycle.
- Zero register: write 0xFFFF to index 31 (ZERO_REG_EN=1) -> index 31 reads 0 and write_collision stays 0 even if both ports target index 31.
- Mid-operation reset: write index 3 = 0xAB in RUN, assert reset_n=0 for one cycle, then attempt a write during CLEAR -> write ignored, ready=0, index 3 reads 0 after the sweep.
- Multi-port read: three ports read indices 1, 1 and 30 after writing 1=0x10 and 30=0x300 -> outputs 0x10, 0x10, 0x300.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-ported integer register file.
// The default widths are also used by the decode stage and hazard unit.
package reg_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int DEFAULT_NUM_READ   = 3;
  localparam int XZR_INDEX          = 31;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  // A write only lands when it is enabled and does not target a hardwired zero register.
  function automatic logic write_lands(input logic en, input logic hits_zero, input logic zero_en);
    return en && !(zero_en && hits_zero);
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle between the register file and its users: packed read ports,
// the two write ports and the status flags.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = DEFAULT_NUM_READ
);

  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr;
  logic [NUM_READ*DATA_WIDTH-1:0] read_data;
  logic                           write_en0;
  logic [ADDR_WIDTH-1:0]          write_addr0;
  logic [DATA_WIDTH-1:0]          write_data0;
  logic                           write_en1;
  logic [ADDR_WIDTH-1:0]          write_addr1;
  logic [DATA_WIDTH-1:0]          write_data1;
  logic                           ready;
  logic                           write_collision;

  modport master (
    output read_addr,
    output write_en0, write_addr0, write_data0,
    output write_en1, write_addr1, write_data1,
    input  read_data,
    input  ready,
    input  write_collision
  );

  modport slave (
    input  read_addr,
    input  write_en0, write_addr0, write_data0,
    input  write_en1, write_addr1, write_data1,
    output read_data,
    output ready,
    output write_collision
  );

endinterface

// File: rtl/reg_file_read_port.sv
// One combinational read port of the register file.
// Forces zero while the clear sweep runs, masks the hardwired zero register,
// and, when REGFILE_BYPASS_EN is defined, forwards same-cycle write data
// (port 1 over port 0, matching the write priority).
module reg_file_read_port #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 5,
  parameter int ZERO_REG    = 31,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic                  in_clear,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] stored_data,
  input  logic                  wr0_live,
  input  logic [ADDR_WIDTH-1:0] wr0_addr,
  input  logic [DATA_WIDTH-1:0] wr0_data,
  input  logic                  wr1_live,
  input  logic [ADDR_WIDTH-1:0] wr1_addr,
  input  logic [DATA_WIDTH-1:0] wr1_data,
  output logic [DATA_WIDTH-1:0] data
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  // Select stored data, optionally overridden by a live write, then apply zero forcing.
  always_comb begin
    data = stored_data;
`ifdef REGFILE_BYPASS_EN
    if (wr0_live && (wr0_addr == addr)) data = wr0_data;
    if (wr1_live && (wr1_addr == addr)) data = wr1_data;
`endif
    if (ZERO_REG_EN && (addr == ZERO_ADDR)) data = '0;
    if (in_clear) data = '0;
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wr0_live, wr0_addr, wr0_data, wr1_live, wr1_addr, wr1_data};
`endif

endmodule

// File: rtl/reg_file_mp.sv
// Multi-ported integer register file: NUM_READ combinational reads, two
// write ports (port 1 wins on a same-index write), hardwired zero register,
// and a post-reset clear sweep that raises ready once every entry is zero.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ    = DEFAULT_NUM_READ,
  parameter int ZERO_REG    = XZR_INDEX,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input logic         clock,
  input logic         reset_n,
  reg_file_mp_if.slave bus
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  rf_state_t             state;
  rf_state_t             next_state;
  logic [ADDR_WIDTH-1:0] clear_idx;
  logic                  ready_q;
  logic                  collision_q;
  logic [DATA_WIDTH-1:0] entries [DEPTH];

  logic in_clear;
  logic clear_last;
  logic wr0_live;
  logic wr1_live;
  logic same_index;

  logic [NUM_READ-1:0][DATA_WIDTH-1:0] read_all;

  // Decide which writes actually land this cycle and where the sweep stands.
  always_comb begin
    in_clear   = (state == CLEAR);
    clear_last = (clear_idx == LAST_ADDR);
    wr0_live   = !in_clear && write_lands(bus.write_en0, bus.write_addr0 == ZERO_ADDR, ZERO_REG_EN);
    wr1_live   = !in_clear && write_lands(bus.write_en1, bus.write_addr1 == ZERO_ADDR, ZERO_REG_EN);
    same_index = (bus.write_addr0 == bus.write_addr1);
  end

  // Next-state logic: leave CLEAR on the edge that clears the final entry.
  always_comb begin
    next_state = state;
    case (state)
      CLEAR: if (clear_last) next_state = RUN;
      RUN:   next_state = RUN;
    endcase
  end

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= CLEAR;
    else          state <= next_state;
  end

  // Sweep pointer walks every index once while clearing.
  always_ff @(posedge clock) begin
    if (!reset_n)      clear_idx <= '0;
    else if (in_clear) clear_idx <= clear_idx + 1'b1;
  end

  // Status flags: ready after the sweep, collision pulse after a same-index dual write.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ready_q     <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      if (in_clear && clear_last) ready_q <= 1'b1;
      collision_q <= wr0_live && wr1_live && same_index;
    end
  end

  // Storage: sweep clearing in CLEAR, otherwise the two write ports with port 1 last.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (in_clear) begin
        entries[clear_idx] <= '0;
      end else begin
        if (wr0_live) entries[bus.write_addr0] <= bus.write_data0;
        if (wr1_live) entries[bus.write_addr1] <= bus.write_data1;
      end
    end
  end

  assign bus.ready           = ready_q;
  assign bus.write_collision = collision_q;
  assign bus.read_data       = read_all;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [ADDR_WIDTH-1:0] port_addr;
    assign port_addr = bus.read_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

    reg_file_read_port #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .ZERO_REG    (ZERO_REG),
      .ZERO_REG_EN (ZERO_REG_EN)
    ) u_port (
      .in_clear    (in_clear),
      .addr        (port_addr),
      .stored_data (entries[port_addr]),
      .wr0_live    (wr0_live),
      .wr0_addr    (bus.write_addr0),
      .wr0_data    (bus.write_data0),
      .wr1_live    (wr1_live),
      .wr1_addr    (bus.write_addr1),
      .wr1_data    (bus.write_data1),
      .data        (read_all[k])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int NR    = 3;
  localparam int DEPTH = 32;
  localparam int ZR    = 31;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  // Free-running clock, 10 time-unit period.
  always #5 clock = ~clock;

  reg_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus ();

  reg_file_mp #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .NUM_READ    (NR),
    .ZERO_REG    (ZR),
    .ZERO_REG_EN (1'b1)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model_mem [DEPTH];
  bit            model_ready = 1'b0;
  bit            model_coll  = 1'b0;
  int            model_swept = 0;
  bit            check_en    = 1'b0;

  task automatic check_output(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (!model_ready) return '0;
    if (a == AW'(ZR)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.write_en1 && bus.write_addr1 == a) return bus.write_data1;
    if (bus.write_en0 && bus.write_addr0 == a) return bus.write_data0;
`endif
    return model_mem[a];
  endfunction

  function automatic logic [DW-1:0] rd(input int k);
    return bus.read_data[k*DW +: DW];
  endfunction

  // Reference model: advance the architectural state on each rising edge.
  always @(posedge clock) begin : model_update
    bit w0;
    bit w1;
    if (!reset_n) begin
      model_swept = 0;
      model_ready = 1'b0;
      model_coll  = 1'b0;
      check_en    = 1'b1;
    end else if (!model_ready) begin
      model_mem[model_swept] = '0;
      model_swept++;
      if (model_swept == DEPTH) model_ready = 1'b1;
      model_coll = 1'b0;
    end else begin
      w0 = bus.write_en0 && (bus.write_addr0 != AW'(ZR));
      w1 = bus.write_en1 && (bus.write_addr1 != AW'(ZR));
      model_coll = w0 && w1 && (bus.write_addr0 == bus.write_addr1);
      if (w0) model_mem[bus.write_addr0] = bus.write_data0;
      if (w1) model_mem[bus.write_addr1] = bus.write_data1;
    end
  end

  // Compare every output against the model mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (check_en) begin
      check_output("ready", DW'(bus.ready), DW'(model_ready));
      check_output("collision", DW'(bus.write_collision), DW'(model_coll));
      for (int k = 0; k < NR; k++)
        check_output($sformatf("read%0d", k), rd(k), model_read(bus.read_addr[k*AW +: AW]));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic en0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic en1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.write_en0   = en0;
    bus.write_addr0 = a0;
    bus.write_data0 = d0;
    bus.write_en1   = en1;
    bus.write_addr1 = a1;
    bus.write_data1 = d1;
  endtask

  task automatic set_reads(input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    bus.read_addr = {r2, r1, r0};
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 4) == 4 ? ZR : $urandom_range(0, 3));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  // Directed scenarios followed by randomized traffic.
  initial begin
    apply_stimulus(0, '0, '0, 0, '0, '0);
    set_reads(0, 0, 0);
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;

    for (int i = 1; i <= DEPTH; i++) begin
      step();
      check_output("sweep_ready", DW'(bus.ready), DW'(i == DEPTH));
    end
    for (int i = 0; i < DEPTH; i += 3) begin
      set_reads(AW'(i), AW'((i + 1) % DEPTH), AW'((i + 2) % DEPTH));
      #1;
      for (int k = 0; k < NR; k++) check_output("post_sweep_zero", rd(k), '0);
      step();
    end

    apply_stimulus(1, 5, 64'hDEAD_BEEF_0000_0001, 0, '0, '0);
    set_reads(0, 0, 5);
    #1;
`ifdef REGFILE_BYPASS_EN
    check_output("basic_same_cycle", rd(2), 64'hDEAD_BEEF_0000_0001);
`else
    check_output("basic_same_cycle", rd(2), '0);
`endif
    step();
    apply_stimulus(0, '0, '0, 0, '0, '0);
    #1;
    check_output("basic_next_cycle", rd(2), 64'hDEAD_BEEF_0000_0001);
    step();

    apply_stimulus(1, 7, 64'h11, 1, 7, 64'h22);
    step();
    apply_stimulus(0, '0, '0, 0, '0, '0);
    set_reads(7, 7, 7);
    #1;
    check_output("collision_data", rd(0), 64'h22);
    check_output("collision_pulse", DW'(bus.write_collision), 64'd1);
    step();
    check_output("collision_clears", DW'(bus.write_collision), 64'd0);

    apply_stimulus(1, 31, 64'hFFFF, 1, 31, 64'hFFFF);
    set_reads(31, 31, 31);
    #1;
    check_output("xzr_same_cycle", rd(1), '0);
    step();
    apply_stimulus(0, '0, '0, 0, '0, '0);
    #1;
    check_output("xzr_read", rd(0), '0);
    check_output("xzr_no_collision", DW'(bus.write_collision), 64'd0);
    step();

    apply_stimulus(1, 1, 64'h10, 1, 30, 64'h300);
    step();
    apply_stimulus(0, '0, '0, 0, '0, '0);
    set_reads(1, 1, 30);
    #1;
    check_output("multi_read0", rd(0), 64'h10);
    check_output("multi_read1", rd(1), 64'h10);
    check_output("multi_read2", rd(2), 64'h300);
    step();

    apply_stimulus(1, 3, 64'hAB, 0, '0, '0);
    step();
    apply_stimulus(0, '0, '0, 0, '0, '0);
    set_reads(3, 0, 1);
    #1;
    check_output("pre_reset_write", rd(0), 64'hAB);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_output("mid_reset_ready", DW'(bus.ready), 64'd0);
    apply_stimulus(1, 0, 64'h55, 1, 3, 64'h66);
    for (int i = 1; i <= DEPTH; i++) begin
      step();
      if (i == DEPTH) apply_stimulus(0, '0, '0, 0, '0, '0);
    end
    #1;
    check_output("resweep_ready", DW'(bus.ready), 64'd1);
    check_output("resweep_idx3", rd(0), '0);
    check_output("resweep_idx0", rd(1), '0);
    check_output("resweep_idx1", rd(2), '0);
    step();

    for (int c = 0; c < 3000; c++) begin
      apply_stimulus(1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom},
                     1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
      set_reads(rand_addr(), rand_addr(), rand_addr());
      reset_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      step();
    end
    reset_n = 1'b1;
    apply_stimulus(0, '0, '0, 0, '0, '0);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
